// File: rtl/adder_serial_n_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: state encoding,
// counter sizing and a parameter legality guard.
package adder_serial_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01
    } state_t;

    // Bits needed to count 0..n-1, never fewer than one.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

`ifndef ADDER_SERIAL_N_CHECK_PARAMS
`define ADDER_SERIAL_N_CHECK_PARAMS
`define ADDER_CHECK_PARAMS(W, D) \
    if ((W) < 2 || (D) < 1 || ((W) % (D)) != 0) begin : g_bad_params \
        $error("adder_serial_n: WIDTH must be >= 2 and a multiple of DIGIT"); \
    end
`endif

// File: rtl/adder_serial_n_if.sv
// Request/result bundle between a requester and the digit-serial adder.
interface adder_serial_n_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/adder_serial_n_digit.sv
// Combinational DIGIT-bit ripple slice; also exports the carry into its top
// bit so the caller can form the signed-overflow flag.
module adder_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic carry;

    always_comb begin
        s        = '0;
        carry    = ci;
        c_msb_in = ci;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                c_msb_in = carry;
            end
            s[i]  = x[i] ^ y[i] ^ carry;
            carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/adder_serial_n.sv
// Multi-cycle adder/subtractor: processes DIGIT bits per clock, LSB digit
// first, with a registered carry; start/busy/done handshake.
module adder_serial_n
    import adder_serial_n_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    adder_serial_n_if.slave   bus
);

    localparam int N  = WIDTH / DIGIT;
    localparam int KW = cnt_width(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    `ADDER_CHECK_PARAMS(WIDTH, DIGIT)

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] slice_s;
    logic             slice_co;
    logic             slice_cmsb;
    logic [WIDTH-1:0] res_shift;

    // Operand registers shift right each cycle, so the live digit is always
    // at the bottom and no digit-indexed mux is needed.
    adder_digit #(.DIGIT(DIGIT)) u_digit (
        .x        (a_q[DIGIT-1:0]),
        .y        (b_q[DIGIT-1:0]),
        .ci       (carry_q),
        .s        (slice_s),
        .co       (slice_co),
        .c_msb_in (slice_cmsb)
    );

    assign res_shift = WIDTH'({slice_s, res_q} >> DIGIT);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        k_d     = k_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    k_d     = '0;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = slice_co;
                res_d   = res_shift;
                k_d     = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d = ST_IDLE;
                    k_d     = '0;
                    sum_d   = res_shift;
                    cout_d  = slice_co;
                    ovf_d   = slice_co ^ slice_cmsb;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_adder_serial_n.sv
// Bench for adder_serial_n: three parameterisations, scoreboard of expected
// results pushed at start and popped at done.
module tb_adder_serial_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_serial_n_if #(.WIDTH(8))  if8 ();
    adder_serial_n_if #(.WIDTH(4))  if4 ();
    adder_serial_n_if #(.WIDTH(16)) if16 ();

    adder_serial_n #(.WIDTH(8),  .DIGIT(2)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    adder_serial_n #(.WIDTH(4),  .DIGIT(1)) u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    adder_serial_n #(.WIDTH(16), .DIGIT(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    typedef struct packed {
        logic        ovf;
        logic        cout;
        logic [31:0] sum;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic exp_t mk(logic [31:0] s, logic c, logic o);
        exp_t r;
        r.sum  = s;
        r.cout = c;
        r.ovf  = o;
        return r;
    endfunction

    // Reference: plain wide addition, overflow from operand/result sign bits.
    function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
        logic [32:0] mask, bop, full;
        exp_t r;
        mask   = (33'd1 << w) - 33'd1;
        bop    = sub ? ((~{1'b0, b}) & mask) : {1'b0, b};
        full   = {1'b0, a} + bop + {32'd0, (sub ? 1'b1 : cin)};
        r.sum  = full[31:0] & mask[31:0];
        r.cout = full[w];
        r.ovf  = (a[w-1] == bop[w-1]) && (r.sum[w-1] != a[w-1]);
        return r;
    endfunction

    task automatic drive(int which, logic [31:0] a, logic [31:0] b, logic cin, logic sub, logic st);
        case (which)
            8: begin
                if8.a = a[7:0]; if8.b = b[7:0]; if8.cin = cin; if8.sub = sub; if8.start = st;
            end
            4: begin
                if4.a = a[3:0]; if4.b = b[3:0]; if4.cin = cin; if4.sub = sub; if4.start = st;
            end
            default: begin
                if16.a = a[15:0]; if16.b = b[15:0]; if16.cin = cin; if16.sub = sub; if16.start = st;
            end
        endcase
    endtask

    function automatic logic get_done(int which);
        case (which)
            8:       return if8.done;
            4:       return if4.done;
            default: return if16.done;
        endcase
    endfunction

    function automatic logic get_busy(int which);
        case (which)
            8:       return if8.busy;
            4:       return if4.busy;
            default: return if16.busy;
        endcase
    endfunction

    function automatic exp_t get_res(int which);
        case (which)
            8:       return mk({24'd0, if8.sum}, if8.cout, if8.ovf);
            4:       return mk({28'd0, if4.sum}, if4.cout, if4.ovf);
            default: return mk({16'd0, if16.sum}, if16.cout, if16.ovf);
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the sampling edge with
    // the operands scrambled, which must not affect the running operation.
    task automatic start_op(int which, logic [31:0] a, logic [31:0] b, logic cin, logic sub, exp_t e);
        sb.push_back(e);
        drive(which, a, b, cin, sub, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(which, ~a, ~b, ~cin, ~sub, 1'b0);
    endtask

    // Edge count includes the start-sampling edge as edge 1.
    task automatic wait_done(int which, int edges_in, output int edges, output int busy_cyc, output bit held);
        exp_t prev;
        prev     = get_res(which);
        edges    = edges_in;
        busy_cyc = 0;
        held     = 1'b1;
        while (!get_done(which) && edges < 30) begin
            if (get_busy(which)) busy_cyc++;
            if (get_res(which) !== prev) held = 1'b0;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(8, 32'hFF, 32'hFF, 1'b1, 1'b0, 1'b1);
        drive(4, 32'hF, 32'hF, 1'b1, 1'b0, 1'b1);
        drive(16, 32'hFFFF, 32'hFFFF, 1'b1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        n_vec++;
        if ({if8.busy, if8.done, if8.cout, if8.ovf, if8.sum} !== 12'd0) begin
            n_err++;
            $display("FAIL reset8: got busy=%b done=%b cout=%b ovf=%b sum=%h, want all 0",
                     if8.busy, if8.done, if8.cout, if8.ovf, if8.sum);
        end
        n_vec++;
        if ({if4.busy, if4.done, if4.cout, if4.ovf, if4.sum, if16.busy, if16.done, if16.cout, if16.ovf, if16.sum} !== 28'd0) begin
            n_err++;
            $display("FAIL reset4_16: outputs not cleared (sum4=%h sum16=%h)", if4.sum, if16.sum);
        end
        drive(8, 0, 0, 1'b0, 1'b0, 1'b0);
        drive(4, 0, 0, 1'b0, 1'b0, 1'b0);
        drive(16, 0, 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (if8.busy !== 1'b0 || if8.done !== 1'b0) begin
                n_err++;
                $display("FAIL idle_after_reset[%0d]: got busy=%b done=%b, want 0 0", i, if8.busy, if8.done);
            end
        end
        $display("reset: done");
    endtask

    task automatic test_add();
        logic [7:0] ta [2] = '{8'd100, 8'hFF};
        logic [7:0] tb [2] = '{8'd27, 8'h01};
        logic       tc [2] = '{1'b1, 1'b0};
        exp_t       te [2];
        exp_t e, got;
        int edges, busy_cyc;
        bit held;
        te[0] = mk(32'h80, 1'b0, 1'b1);
        te[1] = mk(32'h00, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            start_op(8, {24'd0, ta[i]}, {24'd0, tb[i]}, tc[i], 1'b0, te[i]);
            wait_done(8, 1, edges, busy_cyc, held);
            e   = sb.pop_front();
            got = get_res(8);
            $display("add a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b edges=%0d", ta[i], tb[i], tc[i],
                     got.sum[7:0], got.cout, got.ovf, edges);
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL add_result[%0d]: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         i, got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);
            end
            n_vec++;
            if (edges !== 5) begin n_err++; $display("FAIL add_latency[%0d]: got %0d edges, want 5", i, edges); end
            n_vec++;
            if (busy_cyc !== 4) begin n_err++; $display("FAIL add_busy[%0d]: got %0d cycles, want 4", i, busy_cyc); end
            n_vec++;
            if (!held) begin n_err++; $display("FAIL add_hold[%0d]: got outputs changing during RUN, want held", i); end
        end
    endtask

    task automatic test_sub();
        logic [7:0] ta [2] = '{8'd5, 8'h80};
        logic [7:0] tb [2] = '{8'd7, 8'h01};
        exp_t       te [2];
        exp_t e, got;
        int edges, busy_cyc;
        bit held;
        te[0] = mk(32'hFE, 1'b0, 1'b0);
        te[1] = mk(32'h7F, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            start_op(8, {24'd0, ta[i]}, {24'd0, tb[i]}, 1'b1, 1'b1, te[i]);
            wait_done(8, 1, edges, busy_cyc, held);
            e   = sb.pop_front();
            got = get_res(8);
            $display("sub a=%h b=%h -> sum=%h cout=%b ovf=%b edges=%0d", ta[i], tb[i],
                     got.sum[7:0], got.cout, got.ovf, edges);
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL sub_result[%0d]: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         i, got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);
            end
            n_vec++;
            if (edges !== 5) begin n_err++; $display("FAIL sub_latency[%0d]: got %0d edges, want 5", i, edges); end
        end
    endtask

    task automatic test_handshake();
        exp_t e, got;
        int edges, busy_cyc;
        bit held;
        start_op(8, 32'd3, 32'd4, 1'b0, 1'b0, mk(32'd7, 1'b0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        drive(8, 32'd50, 32'd50, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(8, 32'd50, 32'd50, 1'b0, 1'b0, 1'b0);
        wait_done(8, 3, edges, busy_cyc, held);
        e   = sb.pop_front();
        got = get_res(8);
        $display("busy_start a=3 b=4 (start a=50 b=50 while busy) -> sum=%h edges=%0d", got.sum[7:0], edges);
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL busy_start_result: got sum=%h cout=%b ovf=%b, want sum=%h", got.sum, got.cout, got.ovf, e.sum);
        end
        n_vec++;
        if (edges !== 5) begin n_err++; $display("FAIL busy_start_latency: got %0d edges, want 5", edges); end
        // Still inside the done cycle: the next start must be accepted.
        start_op(8, 32'd10, 32'd20, 1'b0, 1'b0, mk(32'd30, 1'b0, 1'b0));
        n_vec++;
        if (if8.done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width: got done=%b, want 0", if8.done); end
        wait_done(8, 1, edges, busy_cyc, held);
        e   = sb.pop_front();
        got = get_res(8);
        $display("back_to_back a=10 b=20 -> sum=%h edges=%0d", got.sum[7:0], edges);
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL b2b_result: got sum=%h cout=%b ovf=%b, want sum=%h", got.sum, got.cout, got.ovf, e.sum);
        end
        n_vec++;
        if (edges !== 5) begin n_err++; $display("FAIL b2b_latency: got %0d edges, want 5", edges); end
        n_vec++;
        if (busy_cyc !== 4) begin n_err++; $display("FAIL b2b_busy: got %0d cycles, want 4", busy_cyc); end
    endtask

    task automatic test_reset_mid();
        exp_t e, got;
        int edges, busy_cyc;
        bit held, seen;
        start_op(8, 32'h11, 32'h22, 1'b0, 1'b0, mk(32'h33, 1'b0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({if8.busy, if8.done, if8.cout, if8.ovf, if8.sum} !== 12'd0) begin
            n_err++;
            $display("FAIL reset_mid_clear: got busy=%b done=%b cout=%b ovf=%b sum=%h, want all 0",
                     if8.busy, if8.done, if8.cout, if8.ovf, if8.sum);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (if8.done) seen = 1'b1;
        end
        $display("reset_mid: aborted op, done seen=%b", seen);
        n_vec++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL reset_mid_no_done: got done pulse, want none"); end
        start_op(8, 32'd12, 32'd13, 1'b0, 1'b0, mk(32'd25, 1'b0, 1'b0));
        wait_done(8, 1, edges, busy_cyc, held);
        e   = sb.pop_front();
        got = get_res(8);
        $display("after_reset a=12 b=13 -> sum=%h edges=%0d", got.sum[7:0], edges);
        n_vec++;
        if (got !== e || edges !== 5) begin
            n_err++;
            $display("FAIL after_reset_op: got sum=%h edges=%0d, want sum=%h edges=5", got.sum, edges, e.sum);
        end
    endtask

    task automatic test_sweep4();
        exp_t e, got;
        int edges, busy_cyc;
        bit held;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int m = 0; m < 4; m++) begin
                    start_op(4, a, b, m[0], m[1], model(4, a, b, m[0], m[1]));
                    wait_done(4, 1, edges, busy_cyc, held);
                    e   = sb.pop_front();
                    got = get_res(4);
                    $display("w4 a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b", a[3:0], b[3:0], m[0], m[1],
                             got.sum[3:0], got.cout, got.ovf);
                    n_vec++;
                    if (got !== e || edges !== 5) begin
                        n_err++;
                        $display("FAIL w4: got sum=%h cout=%b ovf=%b edges=%0d, want sum=%h cout=%b ovf=%b edges=5",
                                 got.sum, got.cout, got.ovf, edges, e.sum, e.cout, e.ovf);
                    end
                end
            end
        end
    endtask

    task automatic test_sweep16();
        exp_t e, got;
        int edges, busy_cyc;
        bit held;
        logic [31:0] a, b;
        logic cin, sub;
        for (int i = 0; i < 1000; i++) begin
            a   = $urandom_range(0, 65535);
            b   = $urandom_range(0, 65535);
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            start_op(16, a, b, cin, sub, model(16, a, b, cin, sub));
            wait_done(16, 1, edges, busy_cyc, held);
            e   = sb.pop_front();
            got = get_res(16);
            $display("w16 a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b", a[15:0], b[15:0], cin, sub,
                     got.sum[15:0], got.cout, got.ovf);
            n_vec++;
            if (got !== e || edges !== 5) begin
                n_err++;
                $display("FAIL w16: got sum=%h cout=%b ovf=%b edges=%0d, want sum=%h cout=%b ovf=%b edges=5",
                         got.sum, got.cout, got.ovf, edges, e.sum, e.cout, e.ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_handshake();
        test_reset_mid();
        test_sweep4();
        test_sweep16();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
